ray_voxel_marcher: RTL and testbench
====================================

Name: ray_voxel_marcher

Overview:
- Downstream stage of the ray generator.
- Accepts one ray per handshake: a 32-bit signed direction vector plus its pixel index, with the camera position sampled at acceptance.
- Marches the ray in fixed steps through a 2^WORLD_BITS cubic voxel grid held in an external synchronous-read occupancy/colour memory.
- Emits one result per ray (hit flag, voxel colour, step count, pixel index) on a valid/ready output toward the framebuffer writer.

Parameters:
FRAC, 8, fractional bits of the internal position accumulator
DIR_SHIFT, 12, arithmetic right shift applied to ray_dir to form the per-step increment
WORLD_BITS, 6, log2 of grid edge length (grid is 64x64x64)
MAX_STEPS, 255, maximum position increments before declaring a miss
STEP_W, 8, width of step counter and pix_steps

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ray_valid  in  1  ray available
ray_ready  out  1  marcher can accept a ray
ray_dir_x, ray_dir_y, ray_dir_z  in  32 each  signed direction components
ray_index  in  32  pixel index of the ray
camera_pos_x, camera_pos_y, camera_pos_z  in  11 each  unsigned camera voxel coordinate
mem_rd_en  out  1  voxel memory read strobe
mem_addr  out  3*WORLD_BITS  voxel address {vz,vy,vx}
mem_rd_data  in  8  voxel value, valid the cycle after mem_rd_en; 0 = empty
pix_valid  out  1  result valid
pix_ready  in  1  downstream accepts result
pix_index  out  32  pixel index of result
pix_hit  out  1  1 = voxel hit
pix_color  out  8  hit voxel value; 0 on miss
pix_steps  out  STEP_W  increments taken before termination

Behaviour:
- Clock and reset: clk is the clock. Reset is reset_n, synchronous, active-low.
- Reset values: state IDLE; pix_valid, pix_hit, pix_color, pix_steps, pix_index, mem_rd_en and mem_addr all 0; ray_ready 0 while reset_n=0.
- ray_ready = (state==IDLE) and reset_n. A ray is accepted on the edge where ray_valid and ray_ready are both 1.
- At acceptance, capture:
  - pos_* = camera_pos_* << FRAC, as 32-bit two's complement;
  - inc_* = ray_dir_* >>> DIR_SHIFT;
  - index = ray_index; steps = 0.
- States:
  - IDLE: on accept, go to BOUNDS.
  - BOUNDS: v_* = pos_* >>> FRAC.
    - If any v < 0 or v >= 2^WORLD_BITS: hit=0, color=0, go to OUTPUT. No read is issued.
    - Else: mem_rd_en=1 for this cycle only, mem_addr={v_z[WB-1:0], v_y, v_x}, go to CHECK.
  - CHECK: sample mem_rd_data.
    - If nonzero: hit=1, color=data, go to OUTPUT.
    - Else if steps==MAX_STEPS: miss, go to OUTPUT.
    - Else: pos_* += inc_* (32-bit wrap, no saturation), steps+=1, go to BOUNDS.
  - OUTPUT: pix_valid=1 with all pix_* held stable. When pix_ready=1, drop pix_valid next cycle and go to IDLE. No new ray is accepted in the same cycle as the result handshake.
- Latency from accept edge T:
  - first pix_valid at T+3 for a hit or miss at steps=0 after a read;
  - T+2 for an immediate out-of-bounds miss;
  - each additional step adds 2 cycles.
- mem_rd_en is never asserted outside BOUNDS; mem_addr holds its last value otherwise.
- A camera position outside the grid yields an immediate miss with steps=0.
- A zero increment marches to MAX_STEPS: miss, MAX_STEPS+1 reads.
- Reset mid-march or mid-OUTPUT: the ray is discarded, outputs go to reset values at the next edge, and state returns to IDLE.

Test Plan:
- Camera (5,5,5), mem[(5,5,5)]=0x3C, ray_index=7, dir arbitrary -> pix_valid at T+3, hit=1, color=0x3C, steps=0, index=7, exactly one mem_rd_en.
- Camera (0,10,10), dir=(0x100000,0,0), only voxel (4,10,10)=0x11 -> hit=1, color=0x11, steps=4, pix_valid at T+11, addresses x=0..4 in order.
- Camera (62,0,0), dir=(0x100000,0,0), empty world -> miss, color=0, steps=2, reads only for x=62,63, pix_valid at T+6.
- Camera (1,0,0), dir=(-0x100000,0,0), empty world -> miss at v_x=-1, steps=2, no read with negative coordinate; camera (100,0,0) -> miss steps=0 at T+2.
- Camera (3,3,3), dir=(0,0,0), empty world -> miss, steps=255, 256 mem_rd_en pulses.
- Hold pix_ready=0 for 5 cycles on a result -> pix_* stable, ray_ready=0. Then reset_n=0 for one cycle mid-march of a second ray -> pix_valid=0, mem_rd_en=0, ray_ready=1 one cycle after reset release, no result emitted for the aborted ray.

Source files
------------

// File: rtl/ray_voxel_marcher.sv
// Fixed-step ray marcher through a cubic voxel grid held in external
// synchronous-read memory; one hit/miss result per accepted ray.
module ray_voxel_marcher #(
   parameter int FRAC       = 8,
   parameter int DIR_SHIFT  = 12,
   parameter int WORLD_BITS = 6,
   parameter int MAX_STEPS  = 255,
   parameter int STEP_W     = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ray_valid,
   output logic                      ray_ready,
   input  logic signed [31:0]        ray_dir_x,
   input  logic signed [31:0]        ray_dir_y,
   input  logic signed [31:0]        ray_dir_z,
   input  logic [31:0]               ray_index,
   input  logic [10:0]               camera_pos_x,
   input  logic [10:0]               camera_pos_y,
   input  logic [10:0]               camera_pos_z,
   output logic                      mem_rd_en,
   output logic [3*WORLD_BITS-1:0]   mem_addr,
   input  logic [7:0]                mem_rd_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic [31:0]               pix_index,
   output logic                      pix_hit,
   output logic [7:0]                pix_color,
   output logic [STEP_W-1:0]         pix_steps
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BOUNDS = 2'd1;
   localparam logic [1:0] CHECK  = 2'd2;
   localparam logic [1:0] OUTPUT = 2'd3;

   logic [1:0]               state;
   logic signed [31:0]       pos_x, pos_y, pos_z;
   logic signed [31:0]       inc_x, inc_y, inc_z;
   logic signed [31:0]       v_x, v_y, v_z;
   logic [31:0]              index;
   logic [STEP_W-1:0]        steps;
   logic                     in_bounds;
   logic [3*WORLD_BITS-1:0]  addr_now;
   logic [3*WORLD_BITS-1:0]  addr_q;

   always_comb begin
      v_x = pos_x >>> FRAC;
      v_y = pos_y >>> FRAC;
      v_z = pos_z >>> FRAC;
      // Upper bits all zero covers both the negative and the too-large case.
      in_bounds = (v_x[31:WORLD_BITS] == '0) &&
                  (v_y[31:WORLD_BITS] == '0) &&
                  (v_z[31:WORLD_BITS] == '0);
      addr_now = {v_z[WORLD_BITS-1:0], v_y[WORLD_BITS-1:0], v_x[WORLD_BITS-1:0]};
   end

   assign ray_ready = (state == IDLE) && reset_n;
   assign mem_rd_en = (state == BOUNDS) && in_bounds;
   // Address is live during the BOUNDS read cycle and otherwise holds the last one issued.
   assign mem_addr  = mem_rd_en ? addr_now : addr_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         pos_x     <= '0;
         pos_y     <= '0;
         pos_z     <= '0;
         inc_x     <= '0;
         inc_y     <= '0;
         inc_z     <= '0;
         index     <= '0;
         steps     <= '0;
         addr_q    <= '0;
         pix_valid <= 1'b0;
         pix_hit   <= 1'b0;
         pix_color <= '0;
         pix_steps <= '0;
         pix_index <= '0;
      end else begin
         addr_q <= mem_addr;
         case (state)
            IDLE: begin
               if (ray_valid) begin
                  pos_x <= 32'(camera_pos_x) << FRAC;
                  pos_y <= 32'(camera_pos_y) << FRAC;
                  pos_z <= 32'(camera_pos_z) << FRAC;
                  inc_x <= ray_dir_x >>> DIR_SHIFT;
                  inc_y <= ray_dir_y >>> DIR_SHIFT;
                  inc_z <= ray_dir_z >>> DIR_SHIFT;
                  index <= ray_index;
                  steps <= '0;
                  state <= BOUNDS;
               end
            end
            BOUNDS: begin
               if (!in_bounds) begin
                  pix_valid <= 1'b1;
                  pix_hit   <= 1'b0;
                  pix_color <= '0;
                  pix_steps <= steps;
                  pix_index <= index;
                  state     <= OUTPUT;
               end else begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (mem_rd_data != '0) begin
                  pix_valid <= 1'b1;
                  pix_hit   <= 1'b1;
                  pix_color <= mem_rd_data;
                  pix_steps <= steps;
                  pix_index <= index;
                  state     <= OUTPUT;
               end else if (steps == STEP_W'(MAX_STEPS)) begin
                  pix_valid <= 1'b1;
                  pix_hit   <= 1'b0;
                  pix_color <= '0;
                  pix_steps <= steps;
                  pix_index <= index;
                  state     <= OUTPUT;
               end else begin
                  pos_x <= pos_x + inc_x;
                  pos_y <= pos_y + inc_y;
                  pos_z <= pos_z + inc_z;
                  steps <= steps + 1'b1;
                  state <= BOUNDS;
               end
            end
            OUTPUT: begin
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_voxel_marcher.sv
// Directed bench for ray_voxel_marcher: a one-voxel memory model, and hand-computed
// hit/miss, step count, latency and read-address expectations per ray.
module tb_ray_voxel_marcher;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               ray_valid = 1'b0;
   logic               ray_ready;
   logic signed [31:0] ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
   logic [31:0]        ray_index = '0;
   logic [10:0]        camera_pos_x = '0, camera_pos_y = '0, camera_pos_z = '0;
   logic               mem_rd_en;
   logic [17:0]        mem_addr;
   logic [7:0]         mem_rd_data = '0;
   logic               pix_valid;
   logic               pix_ready = 1'b0;
   logic [31:0]        pix_index;
   logic               pix_hit;
   logic [7:0]         pix_color;
   logic [7:0]         pix_steps;

   int compared = 0;
   int mismatched = 0;

   // Memory model: at most one occupied voxel.
   logic        hit_en = 1'b0;
   logic [17:0] hit_addr = '0;
   logic [7:0]  hit_val = '0;
   int          rd_count = 0;
   int          rd_base = 0;
   logic [17:0] rd_addrs[$];

   ray_voxel_marcher dut (
      .clk(clk), .reset_n(reset_n),
      .ray_valid(ray_valid), .ray_ready(ray_ready),
      .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
      .ray_index(ray_index),
      .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
      .pix_hit(pix_hit), .pix_color(pix_color), .pix_steps(pix_steps)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= (hit_en && mem_addr == hit_addr) ? hit_val : 8'h00;
         rd_count <= rd_count + 1;
         rd_addrs.push_back(mem_addr);
      end
   end

   function automatic logic [17:0] vaddr(input int x, input int y, input int z);
      return {z[5:0], y[5:0], x[5:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_ray(input logic [10:0] cx, input logic [10:0] cy, input logic [10:0] cz,
                           input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                           input logic [31:0] idx);
      camera_pos_x = cx; camera_pos_y = cy; camera_pos_z = cz;
      ray_dir_x = dx; ray_dir_y = dy; ray_dir_z = dz;
      ray_index = idx;
      ray_valid = 1'b1;
      #1;
      check("ready_before_accept", 32'(ray_ready), 32'd1);
      @(posedge clk); #1;
      ray_valid = 1'b0;
      rd_base = rd_count;
   endtask

   // lat = k where pix_valid is high as seen by the edge T+k (T = accept edge).
   task automatic wait_result(output int lat);
      lat = 0;
      for (int n = 1; n <= 600; n++) begin
         @(posedge clk); #1;
         if (pix_valid) begin
            lat = n + 1;
            break;
         end
      end
      check("valid_seen", 32'(pix_valid), 32'd1);
   endtask

   task automatic check_result(input logic hit, input logic [7:0] color, input logic [7:0] st,
                               input logic [31:0] idx, input int exp_lat, input int lat,
                               input int exp_reads);
      check("hit", 32'(pix_hit), 32'(hit));
      check("color", 32'(pix_color), 32'(color));
      check("steps", 32'(pix_steps), 32'(st));
      check("index", pix_index, idx);
      check("latency", 32'(lat), 32'(exp_lat));
      check("reads", 32'(rd_count - rd_base), 32'(exp_reads));
      check("ready_busy", 32'(ray_ready), 32'd0);
   endtask

   task automatic take_result();
      pix_ready = 1'b1;
      @(posedge clk); #1;
      pix_ready = 1'b0;
      check("valid_drop", 32'(pix_valid), 32'd0);
      check("ready_idle", 32'(ray_ready), 32'd1);
   endtask

   initial begin
      int lat;
      // Reset
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_hit", 32'(pix_hit), 32'd0);
      check("rst_color", 32'(pix_color), 32'd0);
      check("rst_steps", 32'(pix_steps), 32'd0);
      check("rst_index", pix_index, 32'd0);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_ready", 32'(ray_ready), 32'd0);
      reset_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(ray_ready), 32'd1);

      // 1: immediate hit at camera voxel
      hit_en = 1'b1; hit_addr = vaddr(5, 5, 5); hit_val = 8'h3C;
      send_ray(11'd5, 11'd5, 11'd5, 32'h0001_2345, 32'hFFFF_B000, 32'h0000_0777, 32'd7);
      wait_result(lat);
      check_result(1'b1, 8'h3C, 8'd0, 32'd7, 3, lat, 1);
      check("t1_addr", 32'(rd_addrs[rd_base]), 32'(vaddr(5, 5, 5)));
      take_result();

      // 2: march +x from x=0 to hit at x=4
      hit_addr = vaddr(4, 10, 10); hit_val = 8'h11;
      send_ray(11'd0, 11'd10, 11'd10, 32'h0010_0000, 32'd0, 32'd0, 32'd20);
      wait_result(lat);
      check_result(1'b1, 8'h11, 8'd4, 32'd20, 11, lat, 5);
      for (int i = 0; i < 5; i++)
         check("t2_addr", 32'(rd_addrs[rd_base + i]), 32'(vaddr(i, 10, 10)));
      take_result();

      // 3: exit through the high x face
      hit_en = 1'b0;
      send_ray(11'd62, 11'd0, 11'd0, 32'h0010_0000, 32'd0, 32'd0, 32'd30);
      wait_result(lat);
      check_result(1'b0, 8'h00, 8'd2, 32'd30, 6, lat, 2);
      check("t3_addr0", 32'(rd_addrs[rd_base]), 32'(vaddr(62, 0, 0)));
      check("t3_addr1", 32'(rd_addrs[rd_base + 1]), 32'(vaddr(63, 0, 0)));
      take_result();

      // 4a: exit through the low x face (v_x = -1 must not be read)
      send_ray(11'd1, 11'd0, 11'd0, 32'hFFF0_0000, 32'd0, 32'd0, 32'd41);
      wait_result(lat);
      check_result(1'b0, 8'h00, 8'd2, 32'd41, 6, lat, 2);
      check("t4_addr0", 32'(rd_addrs[rd_base]), 32'(vaddr(1, 0, 0)));
      check("t4_addr1", 32'(rd_addrs[rd_base + 1]), 32'(vaddr(0, 0, 0)));
      take_result();

      // 4b: camera outside grid
      send_ray(11'd100, 11'd0, 11'd0, 32'h0010_0000, 32'd0, 32'd0, 32'd42);
      wait_result(lat);
      check_result(1'b0, 8'h00, 8'd0, 32'd42, 2, lat, 0);
      take_result();

      // 5: zero direction runs to MAX_STEPS
      send_ray(11'd3, 11'd3, 11'd3, 32'd0, 32'd0, 32'd0, 32'd55);
      wait_result(lat);
      check_result(1'b0, 8'h00, 8'd255, 32'd55, 513, lat, 256);
      take_result();

      // 6: backpressure, then reset mid-march
      hit_en = 1'b1; hit_addr = vaddr(5, 5, 5); hit_val = 8'h3C;
      send_ray(11'd5, 11'd5, 11'd5, 32'd0, 32'd0, 32'd0, 32'd99);
      wait_result(lat);
      check_result(1'b1, 8'h3C, 8'd0, 32'd99, 3, lat, 1);
      ray_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(pix_valid), 32'd1);
         check("bp_hit", 32'(pix_hit), 32'd1);
         check("bp_color", 32'(pix_color), 32'h3C);
         check("bp_index", pix_index, 32'd99);
         check("bp_ready", 32'(ray_ready), 32'd0);
      end
      ray_valid = 1'b0;
      take_result();

      hit_en = 1'b0;
      send_ray(11'd3, 11'd3, 11'd3, 32'd0, 32'd0, 32'd0, 32'd77);
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort_ready_in_rst", 32'(ray_ready), 32'd0);
      @(posedge clk); #1;
      check("abort_valid", 32'(pix_valid), 32'd0);
      check("abort_rd_en", 32'(mem_rd_en), 32'd0);
      reset_n = 1'b1;
      #1;
      check("abort_ready", 32'(ray_ready), 32'd1);
      rd_base = rd_count;
      begin
         int seen = 0;
         for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (pix_valid) seen++;
         end
         check("abort_no_result", 32'(seen), 32'd0);
         check("abort_no_reads", 32'(rd_count - rd_base), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
